// File: rtl/dbg_pkg.sv
// Shared types and constants for the debug run controller: FSM states,
// config register addresses and reset defaults.
package dbg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    BURST = 2'd2
  } state_t;

  localparam logic [1:0]  CFG_CTRL  = 2'd0;
  localparam logic [1:0]  CFG_BP    = 2'd1;
  localparam logic [1:0]  CFG_BURST = 2'd2;

  localparam logic [15:0] BURST_LEN_RST = 16'd1;

endpackage

// File: rtl/dbg_run_ctrl_sync_edge.sv
// Two-flop synchronizer for an asynchronous level, with a registered copy
// of the synchronized level used to produce a one-cycle rising-edge pulse.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise
);

  logic meta, sync, sync_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      meta   <= d;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~sync_d;

endmodule

// File: rtl/dbg_run_ctrl.sv
// Debug run controller: drives a registered CPU clock for free-run and burst
// stepping, with an optional PC breakpoint compiled in by `define DBG_BP_EN.
module dbg_run_ctrl
  import dbg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        step,
  input  logic [31:0] pc,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic        clk_cpu,
  output logic        halted,
  output logic        bp_hit,
  output logic [31:0] cyc_cnt
);

  state_t      state, state_n;
  logic        clk_cpu_r, clk_cpu_n;
  logic [15:0] remaining, remaining_n;
  logic [15:0] burst_len;
  logic        run_s, step_p;
  logic        unused_run_rise, unused_step_level;
  logic        cpu_edge, bp_match, bp_set;

  sync_edge u_run_sync (
    .clk   (clk),
    .rst   (rst),
    .d     (run),
    .level (run_s),
    .rise  (unused_run_rise)
  );

  sync_edge u_step_sync (
    .clk   (clk),
    .rst   (rst),
    .d     (step),
    .level (unused_step_level),
    .rise  (step_p)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      clk_cpu_r <= 1'b0;
      remaining <= 16'd0;
      cyc_cnt   <= 32'd0;
    end else begin
      state     <= state_n;
      clk_cpu_r <= clk_cpu_n;
      remaining <= remaining_n;
      if (cpu_edge) cyc_cnt <= cyc_cnt + 32'd1;
    end
  end

  // Exits happen only on the high half of a CPU cycle (or a breakpoint on
  // the low half), so clk_cpu never produces a short pulse.
  always_comb begin
    state_n     = state;
    clk_cpu_n   = 1'b0;
    remaining_n = remaining;
    cpu_edge    = 1'b0;
    bp_set      = 1'b0;
    case (state)
      IDLE: begin
        if (run_s) begin
          state_n = RUN;
        end else if (step_p) begin
          state_n     = BURST;
          remaining_n = (burst_len == 16'd0) ? 16'd1 : burst_len;
        end
      end
      RUN, BURST: begin
        if (!clk_cpu_r) begin
          if (bp_match) begin
            state_n = IDLE;
            bp_set  = 1'b1;
          end else begin
            clk_cpu_n = 1'b1;
            cpu_edge  = 1'b1;
            if (state == BURST) remaining_n = remaining - 16'd1;
          end
        end else begin
          if (state == RUN && !run_s) state_n = IDLE;
          if (state == BURST && remaining == 16'd0) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      burst_len <= BURST_LEN_RST;
    end else if (cfg_we && cfg_addr == CFG_BURST) begin
      burst_len <= cfg_wdata[15:0];
    end
  end

`ifdef DBG_BP_EN
  logic        bp_en, skip, bp_hit_r;
  logic [31:0] bp_addr;

  // skip lets a resume from the breakpoint PC execute that instruction once.
  always_ff @(posedge clk) begin
    if (rst) begin
      bp_en    <= 1'b0;
      bp_addr  <= 32'd0;
      bp_hit_r <= 1'b0;
      skip     <= 1'b0;
    end else begin
      if (cfg_we && cfg_addr == CFG_CTRL) bp_en <= cfg_wdata[0];
      if (cfg_we && cfg_addr == CFG_BP) bp_addr <= cfg_wdata;
      if (cfg_we && cfg_addr == CFG_CTRL && cfg_wdata[1]) bp_hit_r <= 1'b0;
      else if (bp_set) bp_hit_r <= 1'b1;
      if (state == IDLE && state_n != IDLE) skip <= 1'b1;
      else if (cpu_edge) skip <= 1'b0;
    end
  end

  assign bp_match = bp_en && (pc == bp_addr) && !skip;
  assign bp_hit   = bp_hit_r;
`else
  logic unused_bits;

  assign bp_match    = 1'b0;
  assign bp_hit      = 1'b0;
  assign unused_bits = ^{pc, cfg_wdata, bp_set};
`endif

  assign clk_cpu = clk_cpu_r;
  assign halted  = (state == IDLE);

endmodule

// File: tb/tb_dbg_run_ctrl.sv
// Self-checking bench for dbg_run_ctrl: a cycle trace table, directed
// sequences for burst/breakpoint/reset corners, and a randomized run.
module tb_dbg_run_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic [31:0] pc;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = 2'd0;
  logic [31:0] cfg_wdata = 32'd0;
  logic        clk_cpu, halted, bp_hit;
  logic [31:0] cyc_cnt;

  int total = 0;
  int bad = 0;

  dbg_run_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .step      (step),
    .pc        (pc),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .clk_cpu   (clk_cpu),
    .halted    (halted),
    .bp_hit    (bp_hit),
    .cyc_cnt   (cyc_cnt)
  );

  always #5 clk = ~clk;

  // CPU model: PC advances by 4 on every rising edge of the gated CPU clock.
  logic [31:0] edge_count = 32'd0;
  logic [31:0] edge_mark = 32'd0;
  logic [31:0] pc_base = 32'h0000_3000;
  always @(posedge clk_cpu) edge_count <= edge_count + 32'd1;
  assign pc = pc_base + ((edge_count - edge_mark) << 2);

  // Reference model: counts active clk cycles since leaving idle; even
  // counts are CPU rising edges, odd counts are the falling halves.
  logic [1:0]  m_rp;
  logic [2:0]  m_sp;
  logic        m_active, m_burst, m_clk;
  int          m_t, m_n;
  logic [31:0] m_cyc;
  logic [15:0] m_blen;

  task automatic model_step();
    logic run_s, step_p;
    if (rst) begin
      m_rp = '0; m_sp = '0; m_active = 1'b0; m_burst = 1'b0; m_clk = 1'b0;
      m_t = 0; m_n = 0; m_cyc = 32'd0; m_blen = 16'd1;
      return;
    end
    run_s  = m_rp[1];
    step_p = m_sp[1] & ~m_sp[2];
    if (!m_active) begin
      if (run_s) begin
        m_active = 1'b1; m_burst = 1'b0; m_t = 0;
      end else if (step_p) begin
        m_active = 1'b1; m_burst = 1'b1; m_t = 0;
        m_n = (m_blen == 16'd0) ? 1 : int'(m_blen);
      end
    end else begin
      if (m_t % 2 == 0) m_cyc = m_cyc + 32'd1;
      else if (m_burst ? ((m_t + 1) / 2 == m_n) : !run_s) m_active = 1'b0;
      m_t++;
    end
    m_clk = m_active && (m_t % 2 == 1);
    if (cfg_we && cfg_addr == 2'd2) m_blen = cfg_wdata[15:0];
    m_rp = {m_rp[0], run};
    m_sp = {m_sp[1:0], step};
  endtask

  task automatic applyStimulus();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, act, expv);
    end
  endtask

  task automatic doReset();
    rst = 1'b1; run = 1'b0; step = 1'b0; cfg_we = 1'b0;
    applyStimulus();
    applyStimulus();
    rst = 1'b0;
    edge_mark = edge_count;
  endtask

  task automatic cfgWrite(input logic [1:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    applyStimulus();
    cfg_we = 1'b0;
  endtask

  task automatic stepPulse();
    step = 1'b1;
    applyStimulus();
    applyStimulus();
    step = 1'b0;
  endtask

  task automatic idleTicks(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  typedef struct {
    logic        run;
    logic        step;
    logic        exp_clk;
    logic        exp_halted;
    logic [31:0] exp_cyc;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic        reached, prev_clk, prev_halted;
    int          toggle_err, step_left;

    // Trace from reset: one default-length step, then a short free run with
    // a step pulse that must be ignored while running.
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'd0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'd1};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'd1};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'd1};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'd1};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'd1};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'd1};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'd2};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'd2};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'd3};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'd3};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'd4};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'd4};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'd4};

    @(posedge clk);
    #1;
    doReset();
    checkOutput("reset_clk_cpu", {31'd0, clk_cpu}, 32'd0);
    checkOutput("reset_halted", {31'd0, halted}, 32'd1);
    checkOutput("reset_bp_hit", {31'd0, bp_hit}, 32'd0);
    checkOutput("reset_cyc_cnt", cyc_cnt, 32'd0);

    for (int i = 0; i < 16; i++) begin
      run = vecs[i].run;
      step = vecs[i].step;
      applyStimulus();
      checkOutput($sformatf("vec%0d_clk_cpu", i), {31'd0, clk_cpu}, {31'd0, vecs[i].exp_clk});
      checkOutput($sformatf("vec%0d_halted", i), {31'd0, halted}, {31'd0, vecs[i].exp_halted});
      checkOutput($sformatf("vec%0d_cyc_cnt", i), cyc_cnt, vecs[i].exp_cyc);
    end

    // Free run for 12 clk, then release.
    doReset();
    toggle_err = 0;
    prev_clk = clk_cpu;
    prev_halted = halted;
    run = 1'b1;
    for (int i = 0; i < 12; i++) begin
      applyStimulus();
      if (!prev_halted && !halted && clk_cpu == prev_clk) toggle_err++;
      prev_clk = clk_cpu;
      prev_halted = halted;
    end
    run = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 10 && !reached; i++) begin
      applyStimulus();
      if (halted) reached = 1'b1;
    end
    checkOutput("run_release_halts", {31'd0, reached}, 32'd1);
    checkOutput("run_toggle", toggle_err, 32'd0);
    checkOutput("run_cyc_5_or_6", {31'd0, (cyc_cnt == 32'd5 || cyc_cnt == 32'd6)}, 32'd1);
    checkOutput("run_halt_clk_low", {31'd0, clk_cpu}, 32'd0);
    checkOutput("run_cyc_vs_edges", cyc_cnt, edge_count - edge_mark);

    // Burst of 3 with a second step pulse arriving mid-burst.
    doReset();
    cfgWrite(2'd2, 32'd3);
    stepPulse();
    reached = 1'b0;
    for (int i = 0; i < 20 && !reached; i++) begin
      applyStimulus();
      if (cyc_cnt == 32'd1) reached = 1'b1;
    end
    checkOutput("burst3_started", {31'd0, reached}, 32'd1);
    stepPulse();
    idleTicks(16);
    checkOutput("burst3_halted", {31'd0, halted}, 32'd1);
    checkOutput("burst3_cyc_cnt", cyc_cnt, 32'd3);
    checkOutput("burst3_edges", edge_count - edge_mark, 32'd3);

    // burst_len of 0 behaves as a single step.
    doReset();
    cfgWrite(2'd2, 32'd0);
    stepPulse();
    idleTicks(10);
    checkOutput("burst0_cyc_cnt", cyc_cnt, 32'd1);
    checkOutput("burst0_edges", edge_count - edge_mark, 32'd1);

    // Breakpoint at 0x3008, then resume by single step.
    doReset();
    cfgWrite(2'd0, 32'd1);
    cfgWrite(2'd1, 32'h0000_3008);
    pc_base = 32'h0000_3000;
    edge_mark = edge_count;
    run = 1'b1;
    reached = 1'b0;
    for (int i = 0; i < 30 && !reached; i++) begin
      applyStimulus();
      if (cyc_cnt == 32'd2) reached = 1'b1;
    end
    checkOutput("bp_reach_cyc2", {31'd0, reached}, 32'd1);
    run = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 20 && !reached; i++) begin
      applyStimulus();
      if (halted) reached = 1'b1;
    end
    checkOutput("bp_halted", {31'd0, reached}, 32'd1);
    checkOutput("bp_clk_low", {31'd0, clk_cpu}, 32'd0);
`ifdef DBG_BP_EN
    checkOutput("bp_pc", pc, 32'h0000_3008);
    checkOutput("bp_hit_set", {31'd0, bp_hit}, 32'd1);
    checkOutput("bp_cyc_cnt", cyc_cnt, 32'd2);
`else
    checkOutput("nobp_pc", pc, 32'h0000_300C);
    checkOutput("nobp_hit", {31'd0, bp_hit}, 32'd0);
    checkOutput("nobp_cyc_cnt", cyc_cnt, 32'd3);
`endif
    idleTicks(4);
    checkOutput("bp_stays_halted", {31'd0, halted}, 32'd1);
    stepPulse();
    idleTicks(10);
`ifdef DBG_BP_EN
    checkOutput("bp_resume_pc", pc, 32'h0000_300C);
    checkOutput("bp_resume_cyc", cyc_cnt, 32'd3);
    checkOutput("bp_hit_sticky", {31'd0, bp_hit}, 32'd1);
`else
    checkOutput("nobp_resume_pc", pc, 32'h0000_3010);
    checkOutput("nobp_resume_cyc", cyc_cnt, 32'd4);
`endif
    cfgWrite(2'd0, 32'd2);
    checkOutput("bp_hit_cleared", {31'd0, bp_hit}, 32'd0);

    // Reset while running with clk_cpu high.
    doReset();
    cfgWrite(2'd2, 32'd5);
    run = 1'b1;
    reached = 1'b0;
    for (int i = 0; i < 30 && !reached; i++) begin
      applyStimulus();
      if (clk_cpu && cyc_cnt >= 32'd2) reached = 1'b1;
    end
    checkOutput("rst_mid_run_reached", {31'd0, reached}, 32'd1);
    rst = 1'b1;
    run = 1'b0;
    applyStimulus();
    checkOutput("rst_mid_clk_cpu", {31'd0, clk_cpu}, 32'd0);
    checkOutput("rst_mid_halted", {31'd0, halted}, 32'd1);
    checkOutput("rst_mid_cyc_cnt", cyc_cnt, 32'd0);
    rst = 1'b0;
    edge_mark = edge_count;
    stepPulse();
    idleTicks(10);
    checkOutput("rst_burst_len_default", cyc_cnt, 32'd1);

    // Randomized traffic against the reference model (breakpoints disabled).
    doReset();
    step_left = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(19) == 0) run = ~run;
      if (step_left > 0) begin
        step = 1'b1;
        step_left--;
      end else begin
        step = 1'b0;
        if ($urandom_range(14) == 0) step_left = int'($urandom_range(3, 1));
      end
      cfg_we = ($urandom_range(9) == 0);
      cfg_addr = 2'($urandom_range(3));
      cfg_wdata = $urandom;
      if (cfg_addr == 2'd2) cfg_wdata[15:0] = 16'($urandom_range(4));
      if (cfg_addr == 2'd0) cfg_wdata[0] = 1'b0;
      rst = ($urandom_range(199) == 0);
      applyStimulus();
      checkOutput("rand_clk_cpu", {31'd0, clk_cpu}, {31'd0, m_clk});
      checkOutput("rand_halted", {31'd0, halted}, {31'd0, !m_active});
      checkOutput("rand_cyc_cnt", cyc_cnt, m_cyc);
      checkOutput("rand_bp_hit", {31'd0, bp_hit}, 32'd0);
    end
    rst = 1'b0;
    cfg_we = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dbg_run_ctrl.md
DBG_RUN_CTRL -- requirements
Module: dbg_run_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 The block SHALL provide these ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- run  in  1  raw run switch (level)
- step  in  1  raw step button
- pc  in  32  current CPU PC
- cfg_we  in  1  config write strobe
- cfg_addr  in  2  config register select
- cfg_wdata  in  32  config write data
- clk_cpu  out  1  registered CPU clock
- halted  out  1  high in IDLE
- bp_hit  out  1  sticky breakpoint-hit flag
- cyc_cnt  out  32  count of clk_cpu rising edges

Function
REQ-003 The block SHALL synchronize run and step through two flops each; step_p SHALL be the rising edge of synchronized step.
REQ-004 The block SHALL implement three states: IDLE, RUN and BURST; halted SHALL be 1 only in IDLE.
REQ-005 In IDLE, clk_cpu SHALL be held 0.
- If synced run=1, the next state SHALL be RUN.
- Else if step_p=1, the next state SHALL be BURST, with remaining loaded from burst_len (0 treated as 1).
- run SHALL take priority over step_p when both apply.
REQ-006 In RUN and BURST, clk_cpu SHALL toggle every clk cycle, so one CPU cycle spans 2 clk.
REQ-007 A CPU edge is the cycle in which clk_cpu_r=0 and toggles to 1; cyc_cnt SHALL increment on each CPU edge and wrap from 0xFFFFFFFF to 0.
REQ-008 Exits from RUN and BURST SHALL occur only from a cycle with clk_cpu_r=1 (clk_cpu next 0), or via breakpoint (REQ-011); clk_cpu SHALL never be truncated to a glitch.
REQ-009 RUN SHALL exit to IDLE when synced run=0 at a clk_cpu_r=1 cycle; step_p SHALL be ignored in RUN.
REQ-010 BURST behaviour:
- remaining SHALL decrement on each CPU edge.
- BURST SHALL exit to IDLE at the clk_cpu_r=1 cycle where remaining=0.
- step_p and run SHALL be ignored in BURST; a run still high is honoured from IDLE on the next cycle.
REQ-011 Breakpoint (when compiled in):
- Check: in RUN or BURST, at a cycle with clk_cpu_r=0, if bp_en=1, pc==bp_addr and skip=0.
- On a hit: clk_cpu SHALL stay 0, the next state SHALL be IDLE, bp_hit SHALL be set to 1, and cyc_cnt SHALL NOT increment.
REQ-012 skip SHALL be set on every IDLE->RUN/BURST transition and cleared at the first CPU edge, so that resuming from a breakpoint PC executes it.
REQ-013 Configuration registers:
- cfg_addr 0 (control): bit0 = bp_en; bit1 = write-1-to-clear bp_hit; a clear SHALL win over a same-cycle set.
- cfg_addr 1: bp_addr[31:0].
- cfg_addr 2: burst_len[15:0].
- cfg_addr 3: writes SHALL be ignored.
REQ-014 Config writes SHALL be accepted in any state, take effect the next clk, and SHALL NOT reload remaining during an active BURST.

Reset
REQ-015 On rst=1 at a clk edge, the block SHALL reset to: state IDLE, clk_cpu=0, halted=1, bp_hit=0, cyc_cnt=0, bp_en=0, bp_addr=0, burst_len=1, remaining=0, skip=0, all sync flops 0.
REQ-016 rst SHALL override every other input, including mid-RUN with clk_cpu=1: clk_cpu SHALL be 0 on the next clk.

Configuration
REQ-017 Macro DBG_BP_EN:
- Defined: breakpoint logic, bp_en, bp_addr and skip SHALL be present per REQ-011/012.
- Undefined: that logic SHALL be absent, bp_hit SHALL be tied 0, and writes to cfg_addr 1 and control bit0 SHALL be ignored.

Structure
REQ-018 Package dbg_pkg SHALL hold the state enum, the cfg address constants (CFG_CTRL=0, CFG_BP=1, CFG_BURST=2), and the reset defaults (burst_len=1).
REQ-019 One sub-module, sync_edge (two-flop synchronizer with level and rising-edge outputs), SHALL be instantiated for run and for step.

Verification
REQ-020 run=1 held for 12 clk after reset -> clk_cpu toggles 0,1,0,1..., cyc_cnt=5 or 6 per alignment; run=0 -> halts at clk_cpu=0, halted=1.
REQ-021 burst_len=3, one step pulse -> exactly 3 CPU edges, then IDLE, cyc_cnt=3; a second step pulse mid-burst is ignored.
REQ-022 With a PC model (pc+=4 per CPU edge from 0x3000), bp_en=1, bp_addr=0x3008, run=1 -> halt with pc=0x3008, bp_hit=1, cyc_cnt=2; run=0 then a step pulse -> pc=0x300C, cyc_cnt=3.
REQ-023 burst_len=0 plus a step pulse -> exactly 1 CPU edge; writing control bit1=1 -> bp_hit=0 next clk.
REQ-024 rst asserted in RUN while clk_cpu=1 -> next clk: clk_cpu=0, IDLE, burst_len=1, cyc_cnt=0.
REQ-025 Build without DBG_BP_EN, replay REQ-022 -> no halt at 0x3008, bp_hit stays 0.
